// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_fetch_pkg;
  localparam int InstrAddrBus = 32;
  localparam int InstrBus     = 32;
  localparam logic RstEnable  = 1'b1;

  localparam logic [InstrBus-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [InstrAddrBus-1:0] pc;
    logic [InstrBus-1:0]     instr;
  } fetch_entry_t;

  function automatic logic [InstrAddrBus-1:0] word_align(input logic [InstrAddrBus-1:0] a);
    return {a[InstrAddrBus-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/ifu_fifo.sv
// Two-entry {pc, instr} buffer between instruction memory and decode.
module ifu_fifo
  import ifu_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);
  fetch_entry_t mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   cnt;
  logic         do_push;
  logic         do_pop;

  // A push into a full buffer is legal only when the head leaves in the same cycle.
  assign do_pop  = pop && (cnt != 2'd0) && !flush;
  assign do_push = push && !flush && ((cnt != 2'd2) || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);
  assign count = cnt;
endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: PC generation, imem request/response handshake,
// squash of wrong-path responses and a 2-entry output buffer to decode.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [InstrAddrBus-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    imem_req_o,
  output logic [InstrAddrBus-1:0] imem_addr_o,
  input  logic                    imem_gnt_i,
  input  logic                    imem_rvalid_i,
  input  logic [InstrBus-1:0]     imem_rdata_i,
  input  logic                    stall_i,
  input  logic                    redirect_i,
  input  logic [InstrAddrBus-1:0] redirect_pc_i,
  output logic [InstrAddrBus-1:0] pc_o,
  output logic [InstrBus-1:0]     instr_o,
  output logic                    valid_o
);
  fetch_state_t            state;
  logic [InstrAddrBus-1:0] fetch_pc;
  logic [1:0]              outstanding;
  logic [1:0]              discard;
  logic [InstrAddrBus-1:0] tag_q [2];
  logic                    tag_rd;
  logic                    tag_wr;

  logic                    rsp;
  logic                    grant;
  logic                    push;
  logic                    pop;
  logic [1:0]              remaining;
  logic [2:0]              in_use;
  logic [1:0]              fifo_count;
  logic                    fifo_full;
  logic                    fifo_empty;
  fetch_entry_t            head;
  fetch_entry_t            entry;

  // Responses with nothing outstanding are stale (e.g. from before a reset).
  assign rsp   = imem_rvalid_i && (outstanding != 2'd0);
  assign grant = imem_req_o && imem_gnt_i;
  assign pop   = valid_o && !stall_i && !redirect_i;
  assign push  = rsp && (state == ST_RUN) && !redirect_i && (!fifo_full || pop);

  // The slot being popped this cycle counts as free, which sustains one
  // instruction per cycle with a single-cycle memory.
  assign in_use    = {1'b0, outstanding} + {1'b0, fifo_count} - {2'b00, pop};
  assign remaining = outstanding - {1'b0, rsp};

  assign imem_req_o  = (state == ST_RUN) && !redirect_i && (in_use < 3'd2);
  assign imem_addr_o = fetch_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state       <= ST_BOOT;
      fetch_pc    <= RESET_PC;
      outstanding <= 2'd0;
      discard     <= 2'd0;
      tag_rd      <= 1'b0;
      tag_wr      <= 1'b0;
    end else begin
      outstanding <= outstanding + {1'b0, grant} - {1'b0, rsp};
      if (grant) tag_wr <= ~tag_wr;
      if (rsp)   tag_rd <= ~tag_rd;

      if (redirect_i)  fetch_pc <= word_align(redirect_pc_i);
      else if (grant)  fetch_pc <= fetch_pc + 32'd4;

      case (state)
        ST_BOOT: state <= ST_RUN;
        ST_RUN: begin
          if (redirect_i) begin
            discard <= remaining;
            if (remaining != 2'd0) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Every response here belongs to the squashed path.
          if (rsp) begin
            discard <= discard - 2'd1;
            if (discard == 2'd1) state <= ST_RUN;
          end
        end
        default: state <= ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (grant) tag_q[tag_wr] <= fetch_pc;
  end

  assign entry.pc    = tag_q[tag_rd];
  assign entry.instr = imem_rdata_i;

  ifu_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_i),
    .wdata (entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign valid_o = !fifo_empty;
  assign pc_o    = valid_o ? head.pc : '0;
  assign instr_o = valid_o ? head.instr : NOP_INSTR;
endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit that feeds the decode stage: holds the fetch PC, issues word requests to instruction memory over a request/grant + response-valid handshake, buffers returned instructions in a 2-entry FIFO, and presents {pc, instr, valid} to the IF/ID boundary. It honours the pipeline stall from the controller and the branch/jump redirect from execute, discarding in-flight responses that belong to the squashed path.

## Interface
- `RESET_PC` — default 32'h0000_0000 — first fetch address after reset.
- `clk` — in — 1 — single clock; all state updates on the rising edge.
- `rst` — in — 1 — reset, asynchronous, active-high.
- `imem_req_o` — out — 1 — request valid to instruction memory.
- `imem_addr_o` — out — 32 — word address of request; bits [1:0] always 0.
- `imem_gnt_i` — in — 1 — memory accepts request this cycle (req && gnt = handshake).
- `imem_rvalid_i` — in — 1 — response valid; responses return in request order, ≥1 cycle after grant.
- `imem_rdata_i` — in — 32 — instruction word with rvalid.
- `stall_i` — in — 1 — decode cannot accept; hold output.
- `redirect_i` — in — 1 — taken branch/jump; flush and refetch.
- `redirect_pc_i` — in — 32 — new fetch target; bits [1:0] ignored (forced 0).
- `pc_o` — out — 32 — address of presented instruction.
- `instr_o` — out — 32 — presented instruction; NOP (32'h0000_0013) when `valid_o`=0.
- `valid_o` — out — 1 — `pc_o`/`instr_o` valid.

## Operation
- State: `fetch_pc` (32b), `outstanding` (0..2), `discard` (0..2), FIFO (2 entries of {pc,instr}), FSM.
- FSM states: BOOT → RUN → DRAIN → RUN.
  - BOOT: one cycle after reset release, no request; → RUN.
  - RUN: `imem_req_o` = (outstanding + fifo_count < 2) && !redirect_i. On req&&gnt: fetch_pc += 4 (wraps mod 2^32), outstanding++.
  - redirect_i in RUN: FIFO flushed, fetch_pc ← {redirect_pc_i[31:2],2'b00}, discard ← outstanding (minus any response arriving same cycle); → DRAIN if resulting discard>0, else stay RUN.
  - DRAIN: no requests; each rvalid decrements discard and outstanding, data dropped; when discard reaches 0 → RUN. redirect_i in DRAIN: fetch_pc updated, keep draining.
- Response in RUN with discard=0: push {pc of that request, imem_rdata_i} into FIFO; outstanding--. The request pc is tracked per outstanding slot (2-deep in-order tag queue).
- Output: FIFO head drives pc_o/instr_o; valid_o = !fifo_empty. Pop when valid_o && !stall_i && !redirect_i.
- Credit rule guarantees FIFO never overflows; push and pop in same cycle allowed.
- Reset values: imem_req_o=0, imem_addr_o=RESET_PC, pc_o=0, instr_o=NOP, valid_o=0, fetch_pc=RESET_PC, counters 0, FIFO empty, FSM=BOOT.

## Timing
- Zero-wait memory (gnt=1, rvalid one cycle after grant): first request cycle 1 after reset release, response cycle 2, valid_o cycle 3; then one instruction per cycle sustained.
- Redirect in cycle N with nothing outstanding: request to target in N+1, valid_o for target in N+3 (no FIFO bypass).
- redirect_i has priority over stall_i, over push, over pop.
- stall_i: outputs held stable; requests continue until credits exhausted.
- imem_addr_o/imem_req_o held stable while req && !gnt, except a redirect may abandon an ungranted request.
- rst asserted mid-operation: all state cleared immediately; responses arriving after release with outstanding=0 are ignored (memory must also be reset).

## Structure
- Shared package/defines: NOP encoding 32'h0000_0013, FSM state encodings, instruction/address bus widths (`InstrAddrBus`, `InstrBus`), `RstEnable`.
- One sub-module: `ifu_fifo` — 2-entry {pc,instr} FIFO with push, pop, flush, full/empty, count.

## Test plan
- Reset, zero-wait memory, RESET_PC=0 → valid_o rises cycle 3 with pc_o=0, then pc_o=4, 8, 12 on consecutive cycles.
- stall_i high 5 cycles at pc_o=8 → pc_o/instr_o hold 8; no more than 2 grants outstanding+buffered; resumes at 12 after release.
- gnt low 3 cycles with req high → imem_addr_o stable; no FIFO push; valid_o drops once FIFO drains.
- redirect_pc_i=0x100 while 2 requests outstanding (2-cycle memory) → both responses dropped, next request addr 0x100, next valid pc_o=0x100.
- redirect_pc_i=0x203 → fetch address 0x200; redirect concurrent with stall → flush wins, valid_o=0 next cycle.
- rst asserted with FIFO full → valid_o=0, instr_o=NOP immediately; after release fetch restarts at RESET_PC.
